// File: rtl/tff_updown_counter.sv
// Up/down counter over 0..limit built from per-bit toggle registers, with zero-latency tc and a sticky wrap flag.
// Latency: count and wrap update one clk edge after sampling; there is no backpressure and the counter always accepts its inputs.
module tff_updown_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] limit,
    input  logic             clr_wrap,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             at_top;
    logic             at_zero;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] t;

    always_comb begin
        at_top   = (count >= limit);
        at_zero  = (count == '0);
        tc       = en & ~load & ((up & at_top) | (~up & at_zero));
        step_val = '0;
        if (up) begin
            step_val = at_top ? '0 : count + ONE;
        end else begin
            step_val = at_zero ? limit : count - ONE;
        end
        // Each toggle bit flips wherever the current value and the target value differ.
        t = '0;
        if (load) begin
            t = count ^ din;
        end else if (en) begin
            t = count ^ step_val;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count ^ t;
            if (tc) begin
                wrap <= 1'b1;
            end else if (clr_wrap) begin
                wrap <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tff_updown_counter.sv
// Randomized and directed bench for tff_updown_counter, including an 8-bit cascade of two 4-bit stages.
module tb_tff_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] din = '0;
    logic [3:0] limit = '0;
    logic       clr_wrap = 1'b0;
    logic [3:0] count;
    logic       tc;
    logic       wrap;

    logic       cen = 1'b0;
    logic       cup = 1'b0;
    logic [3:0] c1_count;
    logic [3:0] c2_count;
    logic       c1_tc;
    logic       c2_tc;
    logic       c1_wrap;
    logic       c2_wrap;

    always #5 clk = ~clk;

    tff_updown_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .din(din),
        .limit(limit), .clr_wrap(clr_wrap), .count(count), .tc(tc), .wrap(wrap)
    );

    tff_updown_counter #(.WIDTH(4)) c1 (
        .clk(clk), .rst(rst), .en(cen), .up(cup), .load(1'b0), .din(4'd0),
        .limit(4'd15), .clr_wrap(1'b0), .count(c1_count), .tc(c1_tc), .wrap(c1_wrap)
    );

    tff_updown_counter #(.WIDTH(4)) c2 (
        .clk(clk), .rst(rst), .en(c1_tc), .up(cup), .load(1'b0), .din(4'd0),
        .limit(4'd15), .clr_wrap(1'b0), .count(c2_count), .tc(c2_tc), .wrap(c2_wrap)
    );

    typedef struct {
        logic       chk_tc;
        logic       tc;
        logic [3:0] cnt;
        logic       wr;
        logic [7:0] cval;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference state: counter value, sticky flag, and the cascade as one 8-bit number.
    int   m_count = 0;
    bit   m_wrap = 0;
    int   m_casc = 0;
    bit   m_known = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [3:0] d, input logic e,
                         input logic u, input logic [3:0] lim, input logic c,
                         input logic ce, input logic cu);
        exp_t x;
        @(negedge clk);
        rst = r; load = ld; din = d; en = e; up = u; limit = lim; clr_wrap = c;
        cen = ce; cup = cu;
        x.chk_tc = m_known;
        x.tc = e && !ld && ((u && m_count >= int'(lim)) || (!u && m_count == 0));
        if (r) begin
            m_count = 0;
            m_wrap  = 0;
            m_casc  = 0;
            m_known = 1;
        end else begin
            if (ld) begin
                m_count = int'(d);
            end else if (e) begin
                if (u) m_count = (m_count >= int'(lim)) ? 0 : m_count + 1;
                else   m_count = (m_count == 0) ? int'(lim) : m_count - 1;
            end
            if (x.tc) m_wrap = 1;
            else if (c) m_wrap = 0;
            if (ce) m_casc = cu ? (m_casc + 1) % 256 : (m_casc + 255) % 256;
        end
        x.cnt  = 4'(m_count);
        x.wr   = m_wrap;
        x.cval = 8'(m_casc);
        q.push_back(x);
    endtask

    // Monitor: tc is sampled before the edge, registered outputs just after it.
    initial begin
        exp_t e;
        logic tc_s;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                tc_s = tc;
                @(posedge clk);
                #1;
                e = q.pop_front();
                if (e.chk_tc) check("tc", {7'd0, tc_s}, {7'd0, e.tc});
                check("count", {4'd0, count}, {4'd0, e.cnt});
                check("wrap", {7'd0, wrap}, {7'd0, e.wr});
                check("cascade", {c2_count, c1_count}, e.cval);
            end
        end
    end

    initial begin
        // Reset, then full up-count over 0..15.
        drive(1, 0, 0, 0, 1, 15, 0, 0, 0);
        drive(1, 0, 0, 0, 1, 15, 0, 0, 0);
        for (int i = 0; i < 17; i++) drive(0, 0, 0, 1, 1, 15, 0, 0, 0);

        // Down-count with limit 9 from 0.
        drive(1, 0, 0, 0, 0, 9, 0, 0, 0);
        for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 0, 9, 0, 0, 0);

        // Load above limit, wrap from outside the range, reverse, load beats enable.
        drive(0, 1, 12, 0, 1, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 0, 5, 0, 0, 0);
        drive(0, 1, 3, 1, 1, 5, 0, 0, 0);

        // Clear on a non-wrap edge, then clear colliding with a wrap.
        drive(0, 0, 0, 1, 1, 5, 1, 0, 0);
        drive(0, 0, 0, 1, 1, 5, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 5, 1, 0, 0);
        drive(0, 0, 0, 0, 1, 5, 0, 0, 0);

        // Zero limit in both directions.
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 0, 0, 0, 0);

        // Reset mid-count at 7 with wrap set.
        drive(0, 1, 7, 0, 1, 15, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 15, 0, 0, 0);
        drive(1, 0, 0, 1, 1, 15, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 15, 0, 0, 0);

        // Cascade: full 8-bit range up then down.
        drive(1, 0, 0, 0, 1, 15, 0, 0, 0);
        for (int i = 0; i < 257; i++) drive(0, 0, 0, 0, 1, 15, 0, 1, 1);
        for (int i = 0; i < 257; i++) drive(0, 0, 0, 0, 1, 15, 0, 1, 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            drive(($urandom_range(0, 40) == 0), ($urandom_range(0, 7) == 0),
                  4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tff_updown_counter.md
TFF_UPDOWN_COUNTER -- requirements
Module: tff_updown_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-004 SHALL have port en, input, 1, count enable; one step per enabled clk edge.
REQ-005 SHALL have port up, input, 1, direction; 1 = count up, 0 = count down.
REQ-006 SHALL have port load, input, 1, synchronous parallel load strobe.
REQ-007 SHALL have port din, input, WIDTH, parallel load value.
REQ-008 SHALL have port limit, input, WIDTH, terminal value; count range is 0..limit.
REQ-009 SHALL have port clr_wrap, input, 1, clears the sticky wrap flag.
REQ-010 SHALL have port count, output, WIDTH, registered counter value.
REQ-011 SHALL have port tc, output, 1, combinational terminal-count / cascade carry-borrow.
REQ-012 SHALL have port wrap, output, 1, registered sticky flag; set on any wrap-around.

Function
REQ-013 Each count bit SHALL be a toggle register: bit_i(next) = bit_i XOR t_i; t_i derived from count, up, limit and en.
REQ-014 Priority per clk edge SHALL be: rst > load > en; all other cases hold count.
REQ-015 load=1: count <= din next edge, regardless of en/up; din > limit SHALL be stored unmodified.
REQ-016 en=1, up=1, count < limit: count <= count+1.
REQ-017 en=1, up=1, count >= limit: count <= 0 (wrap); also covers count > limit after load or limit change.
REQ-018 en=1, up=0, count != 0: count <= count-1 (including values above limit).
REQ-019 en=1, up=0, count == 0: count <= limit (wrap).
REQ-020 limit == 0: enabled steps SHALL keep count at 0 and every enabled step counts as a wrap.
REQ-021 tc SHALL equal en & ~load & ((up & count >= limit) | (~up & count == 0)); asserted same cycle as the step that wraps, zero latency, for cascading a next-stage en.
REQ-022 wrap SHALL be set on the edge where a wrap (REQ-017/019/020) occurs; held until clr_wrap or rst.
REQ-023 clr_wrap and a wrap on the same edge: set wins, wrap = 1.
REQ-024 up changing between enabled cycles SHALL take effect on the next edge, no dead cycle.
REQ-025 Latency: count reflects load/step one clk edge after the controlling inputs are sampled.
REQ-026 Arithmetic SHALL be modulo the 0..limit range only; no 2^WIDTH rollover is ever visible unless limit = 2^WIDTH-1.

Reset
REQ-027 rst=1 at an edge: count <= 0, wrap <= 0; overrides load, en, clr_wrap.
REQ-028 During rst=1, tc SHALL follow REQ-021 from current count; consumers gate with rst.
REQ-029 rst asserted mid-count SHALL take effect at the next edge with no partial update; count resumes from 0 after release.

Verification
REQ-030 rst 2 cycles, limit=15, up=1, en=1 for 17 cycles -> count 0,1..15,0; tc high only while count=15; wrap=1 after the 15->0 edge.
REQ-031 limit=9, up=0, en=1 from count=0 -> 9,8..0,9; tc high while count=0; wrap set at first 0->9 edge.
REQ-032 limit=5, load din=12, then up=1 en=1 -> 12,0,1; then up=0 from 1 -> 0,5; load with en=1 same edge -> din wins.
REQ-033 wrap=1, clr_wrap=1 on non-wrap edge -> wrap=0; clr_wrap=1 on a wrap edge -> wrap stays 1.
REQ-034 limit=0, en=1 either direction -> count stays 0, tc=1 each cycle, wrap=1; rst asserted mid-sequence at count=7 (limit=15) -> count=0, wrap=0 next edge.
REQ-035 Two instances cascaded (stage2 en = stage1 tc), limit=15 both, up=1 -> combined 8-bit count increments 0..255 and wraps to 0; repeat with up=0 -> 255..0 wrap.
